// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the timer arbiter slice.
//   state_t : arbiter FSM encoding (IDLE, LOAD, RUN, FIN)
//   TMR_W   : default duration / prog_timer count width
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam int TMR_W = 24;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : index with highest priority this round
//   idx   : first set request at or after ptr, wrapping modulo N
//   valid : at least one request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin
        logic [PW-1:0] c;
        idx   = '0;
        valid = 1'b0;
        c     = '0;
        // Scan from farthest to nearest so the nearest hit is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            c = PW'((int'(ptr) + k) % N);
            if (req[c]) begin
                idx   = c;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one external prog_timer among N requesters.
// Grants round-robin, loads the owner's duration, runs the countdown and
// pulses done[owner] on expiry. Dropping req[owner] while loading/running
// aborts the interval with no done pulse.
//   clk, reset          : clock, async active-high reset
//   req[N]              : level requests, held until done or cancel
//   dur[N*W]            : per-requester durations, dur[i*W +: W]
//   gnt[N]              : one-hot owner of the timer
//   done[N]             : one-cycle expiry pulse to the owner
//   busy                : FSM not idle
//   tmr_load/tmr_value  : load strobe and value to prog_timer
//   tmr_en              : count enable to prog_timer
//   tmr_zero            : prog_timer count==0 flag
// All outputs are registered.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = TMR_W,
    parameter int PW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dur,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic           tmr_load,
    output logic [W-1:0]   tmr_value,
    output logic           tmr_en,
    input  logic           tmr_zero
);

    state_t        state_q, state_n;
    logic [PW-1:0] owner_q, owner_n;
    logic [PW-1:0] ptr_q, ptr_n;
    logic          first_q, first_n;   // first RUN cycle: tmr_zero still stale
    logic [PW-1:0] owner_inc;

    logic [N-1:0]  gnt_n, done_n;
    logic          busy_n, load_n, en_n;
    logic [W-1:0]  value_n;

    logic [PW-1:0] pick_idx;
    logic          pick_vld;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign owner_inc = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        first_n = 1'b0;
        gnt_n   = gnt;
        done_n  = '0;
        load_n  = 1'b0;
        en_n    = tmr_en;
        value_n = tmr_value;

        case (state_q)
            S_IDLE: begin
                gnt_n = '0;
                en_n  = 1'b0;
                if (pick_vld) begin
                    owner_n         = pick_idx;
                    gnt_n[pick_idx] = 1'b1;
                    value_n         = dur[pick_idx*W +: W];
                    load_n          = 1'b1;
                    state_n         = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!req[owner_q]) begin
                    gnt_n   = '0;
                    en_n    = 1'b0;
                    ptr_n   = owner_inc;
                    state_n = S_IDLE;
                end else if (tmr_value == '0) begin
                    // Nothing to count: finish without ever enabling the timer.
                    gnt_n          = '0;
                    en_n           = 1'b0;
                    done_n[owner_q] = 1'b1;
                    state_n        = S_FIN;
                end else begin
                    en_n    = 1'b1;
                    first_n = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[owner_q]) begin
                    gnt_n   = '0;
                    en_n    = 1'b0;
                    ptr_n   = owner_inc;
                    state_n = S_IDLE;
                end else if (!first_q && tmr_zero) begin
                    gnt_n          = '0;
                    en_n           = 1'b0;
                    done_n[owner_q] = 1'b1;
                    state_n        = S_FIN;
                end
            end
            S_FIN: begin
                gnt_n   = '0;
                en_n    = 1'b0;
                ptr_n   = owner_inc;
                state_n = S_IDLE;
            end
            default: begin
                gnt_n   = '0;
                en_n    = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tmr_load  <= 1'b0;
            tmr_en    <= 1'b0;
            tmr_value <= '0;
        end else begin
            state_q   <= state_n;
            owner_q   <= owner_n;
            ptr_q     <= ptr_n;
            first_q   <= first_n;
            gnt       <= gnt_n;
            done      <= done_n;
            busy      <= busy_n;
            tmr_load  <= load_n;
            tmr_en    <= en_n;
            tmr_value <= value_n;
        end
    end

endmodule
